apb_cfg_seq: RTL and testbench

//  APB master that programs the matrix-multiplier top over config_bus: on start it writes N_CFG

---
 rtl/apb_cfg_seq.sv | 182 ++++++++++++++++++
 tb/tb_apb_cfg_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cfg_seq.sv
// APB configuration sequencer: writes N_CFG config words and a GO command,
// then polls a status register until its done bit sets, a slave error, or a timeout.
module apb_cfg_seq #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                N_CFG     = 4,
    parameter logic [ADDR_W-1:0] CFG_BASE  = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] GO_ADDR   = 32'h0000_0040,
    parameter logic [DATA_W-1:0] GO_DATA   = 32'h0000_0001,
    parameter logic [ADDR_W-1:0] STAT_ADDR = 32'h0000_0044,
    parameter logic [DATA_W-1:0] DONE_MASK = 32'h0000_0001,
    parameter int                POLL_GAP  = 8,
    parameter int                MAX_POLLS = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [N_CFG*DATA_W-1:0] cfg_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_W-1:0]       paddr,
    output logic [DATA_W-1:0]       pwdata,
    input  logic [DATA_W-1:0]       prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    // state    | meaning
    // IDLE     | waiting for start, APB idle
    // W_SETUP  | write setup phase: config word idx, or GO once idx==N_CFG
    // W_ACCESS | write access phase, waiting for pready
    // R_SETUP  | status read setup phase
    // R_ACCESS | status read access phase, waiting for pready
    // GAP      | idle spacing between status reads
    typedef enum logic [2:0] {
        S_IDLE, S_W_SETUP, S_W_ACCESS, S_R_SETUP, S_R_ACCESS, S_GAP
    } state_t;

    localparam int IDX_W  = $clog2(N_CFG + 1);
    localparam int POLL_W = $clog2(MAX_POLLS + 1);
    localparam int GAP_W  = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    state_t                    r_state, w_state_nxt;
    logic [IDX_W-1:0]          r_idx, w_idx_nxt;
    logic [POLL_W-1:0]         r_polls, w_polls_nxt;
    logic [GAP_W-1:0]          r_gap, w_gap_nxt;
    logic [N_CFG*DATA_W-1:0]   r_cfg, w_cfg_nxt;
    logic                      r_busy, w_busy_nxt;
    logic                      r_done, w_done_nxt;
    logic                      r_err, w_err_nxt;
    logic                      w_is_go;
    logic [ADDR_W-1:0]         w_waddr;
    logic [DATA_W-1:0]         w_wdata;

    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

    assign w_is_go = (r_idx == IDX_W'(N_CFG));
    assign w_waddr = w_is_go ? GO_ADDR : (CFG_BASE + (ADDR_W'(r_idx) << 2));
    assign w_wdata = w_is_go ? GO_DATA : DATA_W'(r_cfg >> (r_idx * DATA_W));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_polls <= '0;
            r_gap   <= '0;
            r_cfg   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_polls <= w_polls_nxt;
            r_gap   <= w_gap_nxt;
            r_cfg   <= w_cfg_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_polls_nxt = r_polls;
        w_gap_nxt   = r_gap;
        w_cfg_nxt   = r_cfg;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        psel        = 1'b0;
        penable     = 1'b0;
        pwrite      = 1'b0;
        paddr       = '0;
        pwdata      = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_cfg_nxt   = cfg_data;
                    w_idx_nxt   = '0;
                    w_polls_nxt = '0;
                    w_err_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_W_SETUP;
                end
            end
            S_W_SETUP: begin
                psel        = 1'b1;
                pwrite      = 1'b1;
                paddr       = w_waddr;
                pwdata      = w_wdata;
                w_state_nxt = S_W_ACCESS;
            end
            S_W_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                pwrite  = 1'b1;
                paddr   = w_waddr;
                pwdata  = w_wdata;
                if (pready) begin
                    if (pslverr) begin
                        w_err_nxt   = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else if (!w_is_go) begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = S_W_SETUP;
                    end else begin
                        w_state_nxt = S_R_SETUP;
                    end
                end
            end
            S_R_SETUP: begin
                psel        = 1'b1;
                paddr       = STAT_ADDR;
                w_state_nxt = S_R_ACCESS;
            end
            S_R_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                paddr   = STAT_ADDR;
                if (pready) begin
                    if (pslverr) begin
                        w_err_nxt   = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else if ((prdata & DONE_MASK) != '0) begin
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_polls_nxt = r_polls + POLL_W'(1);
                        if (r_polls == POLL_W'(MAX_POLLS - 1)) begin
                            w_err_nxt   = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = S_IDLE;
                        end else if (POLL_GAP == 0) begin
                            w_state_nxt = S_R_SETUP;
                        end else begin
                            // down-counter: GAP lasts exactly POLL_GAP cycles
                            w_gap_nxt   = GAP_W'(POLL_GAP - 1);
                            w_state_nxt = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                if (r_gap == '0) w_state_nxt = S_R_SETUP;
                else             w_gap_nxt   = r_gap - GAP_W'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_cfg_seq.sv
// Bench for apb_cfg_seq: a transaction-level model builds the cycle-by-cycle
// slave responses and expected outputs; one process compares the DUT each cycle.
module tb_apb_cfg_seq;

    localparam int N  = 4;
    localparam int PG = 8;
    localparam int MP = 4;
    localparam int CW = N * 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [CW-1:0] cfg_data;
    logic          busy, done, err;
    logic          psel, penable, pwrite;
    logic [31:0]   paddr, pwdata, prdata;
    logic          pready, pslverr;

    apb_cfg_seq #(
        .ADDR_W(32), .DATA_W(32), .N_CFG(N),
        .CFG_BASE(32'h0000_0000), .GO_ADDR(32'h0000_0040), .GO_DATA(32'h0000_0001),
        .STAT_ADDR(32'h0000_0044), .DONE_MASK(32'h0000_0001),
        .POLL_GAP(PG), .MAX_POLLS(MP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cfg_data(cfg_data),
        .busy(busy), .done(done), .err(err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        logic [CW-1:0] cfg;
        logic          pready;
        logic          pslverr;
        logic [31:0]   prdata;
        logic          psel, pen, pwr;
        logic [31:0]   paddr, pwdata;
        logic          busy, done, err;
    } cyc_t;

    cyc_t  q[$];
    cyc_t  exp_cur;
    logic  chk_valid = 1'b0;
    int    cyc_idx   = 0;
    int    checks    = 0;
    int    errors    = 0;

    logic  m_busy, m_done, m_err;
    int    obs_busy, obs_done_cnt, obs_done_at, obs_reads, obs_go;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s cyc %0d actual %h required %h", nm, cyc_idx, act, ex);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (chk_valid) begin
            chk("psel",    {31'd0, psel},    {31'd0, exp_cur.psel});
            chk("penable", {31'd0, penable}, {31'd0, exp_cur.pen});
            chk("pwrite",  {31'd0, pwrite},  {31'd0, exp_cur.pwr});
            chk("paddr",   paddr,            exp_cur.paddr);
            chk("pwdata",  pwdata,           exp_cur.pwdata);
            chk("busy",    {31'd0, busy},    {31'd0, exp_cur.busy});
            chk("done",    {31'd0, done},    {31'd0, exp_cur.done});
            chk("err",     {31'd0, err},     {31'd0, exp_cur.err});
            obs_busy += int'(busy);
            if (done) begin
                obs_done_cnt++;
                obs_done_at = cyc_idx;
            end
            if (psel && !penable && !pwrite) obs_reads++;
            if (psel && !penable && pwrite && paddr == 32'h40) obs_go++;
        end
    end

    function automatic logic [CW-1:0] rcfg();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic noise();
        return m_busy && ($urandom_range(0, 3) == 0);
    endfunction

    task automatic push(input logic st, input logic pr, input logic se, input logic [31:0] rd,
                        input logic ps, input logic pe, input logic pw,
                        input logic [31:0] pa, input logic [31:0] pd, input logic [CW-1:0] cfg);
        cyc_t c;
        c.start = st;  c.cfg = cfg;  c.pready = pr;  c.pslverr = se;  c.prdata = rd;
        c.psel = ps;   c.pen = pe;   c.pwr = pw;     c.paddr = pa;    c.pwdata = pd;
        c.busy = m_busy;  c.done = m_done;  c.err = m_err;
        q.push_back(c);
        m_done = 1'b0;
    endtask

    task automatic idle_push();
        push(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
             1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rcfg());
    endtask

    // one APB transfer: setup, `waits` wait states, then the completing access cycle
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int waits, input logic se, input logic [31:0] rd);
        logic [31:0] wd;
        wd = wr ? d : 32'h0;
        push(noise(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
             1'b1, 1'b0, wr, a, wd, rcfg());
        for (int i = 0; i < waits; i++)
            push(noise(), 1'b0, 1'($urandom_range(0, 1)), $urandom | 32'h1,
                 1'b1, 1'b1, wr, a, wd, rcfg());
        push(noise(), 1'b1, se, rd, 1'b1, 1'b1, wr, a, wd, rcfg());
    endtask

    task automatic build_run(input logic [CW-1:0] cfg, input int wmax_w, input int wmax_r,
                             input bit wfix, input int err_at, input int done_at);
        int          w;
        logic [31:0] rd;
        push(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
             1'b0, 1'b0, 1'b0, 32'h0, 32'h0, cfg);
        m_busy = 1'b1;
        m_err  = 1'b0;
        for (int i = 0; i <= N; i++) begin
            w = wfix ? wmax_w : $urandom_range(0, wmax_w);
            if (i < N) xfer(1'b1, 32'(4 * i), cfg[i*32 +: 32], w, err_at == i, $urandom);
            else       xfer(1'b1, 32'h40, 32'h1, w, err_at == i, $urandom);
            if (err_at == i) begin
                m_err = 1'b1; m_busy = 1'b0; return;
            end
        end
        for (int p = 0; p < MP; p++) begin
            rd    = $urandom;
            rd[0] = (p == done_at);
            w     = wfix ? wmax_r : $urandom_range(0, wmax_r);
            xfer(1'b0, 32'h44, 32'h0, w, err_at == N + 1 + p, rd);
            if (err_at == N + 1 + p) begin
                m_err = 1'b1; m_busy = 1'b0; return;
            end
            if (p == done_at) begin
                m_done = 1'b1; m_busy = 1'b0; return;
            end
            if (p == MP - 1) begin
                m_err = 1'b1; m_busy = 1'b0; return;
            end
            for (int g = 0; g < PG; g++)
                push(noise(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                     1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rcfg());
        end
    endtask

    task automatic play();
        obs_busy = 0; obs_done_cnt = 0; obs_done_at = -1; obs_reads = 0; obs_go = 0;
        for (int k = 0; k < 3; k++) idle_push();
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            #1;
            start    = q[k].start;
            cfg_data = q[k].cfg;
            pready   = q[k].pready;
            pslverr  = q[k].pslverr;
            prdata   = q[k].prdata;
            exp_cur  = q[k];
            cyc_idx  = k;
            chk_valid = 1'b1;
        end
        @(negedge clk);
        #1;
        chk_valid = 1'b0;
        start  = 1'b0;
        pready = 1'b0;
        q.delete();
    endtask

    logic [CW-1:0] cfg_a;

    initial begin
        reset_n = 1'b0; start = 1'b0; cfg_data = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
        #1;
        chk("rst_outs", {24'd0, psel, penable, pwrite, busy, done, err, 2'b00}, 32'h0);
        chk("rst_paddr", paddr | pwdata, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        cfg_a = {32'd4, 32'd3, 32'd2, 32'd1};
        build_run(cfg_a, 0, 0, 1'b1, -1, 0);
        play();
        chk("t1_done_at", 32'(obs_done_at), 32'd13);
        chk("t1_busy_cycles", 32'(obs_busy), 32'd12);
        chk("t1_reads", 32'(obs_reads), 32'd1);

        build_run(cfg_a, 3, 0, 1'b1, -1, 0);
        play();
        chk("t2_done_at", 32'(obs_done_at), 32'd28);

        build_run(rcfg(), 0, 0, 1'b1, -1, 3);
        play();
        chk("t3_reads", 32'(obs_reads), 32'd4);
        chk("t3_done_cnt", 32'(obs_done_cnt), 32'd1);

        build_run(rcfg(), 0, 0, 1'b1, 2, 0);
        play();
        chk("t4_go_writes", 32'(obs_go), 32'd0);
        chk("t4_reads", 32'(obs_reads), 32'd0);
        chk("t4_err", {31'd0, err}, 32'd1);

        build_run(rcfg(), 1, 1, 1'b0, -1, -1);
        play();
        chk("t5_reads", 32'(obs_reads), 32'd4);
        chk("t5_done_cnt", 32'(obs_done_cnt), 32'd0);
        chk("t5_err", {31'd0, err}, 32'd1);

        for (int r = 0; r < 40; r++) begin
            build_run(rcfg(), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N + 4)) : -1,
                      ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, MP - 1)));
            play();
        end

        // reset asserted while a write access is stalled
        @(negedge clk); #1;
        start = 1'b1; cfg_data = rcfg(); pready = 1'b0;
        @(negedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        chk("t6_pre_access", {29'd0, psel, penable, busy}, 32'h7);
        reset_n = 1'b0;
        #1;
        chk("t6_in_reset", {29'd0, psel, penable, busy}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
        build_run(cfg_a, 0, 0, 1'b1, -1, 0);
        play();
        chk("t6_done_at", 32'(obs_done_at), 32'd13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
